// File: rtl/dpram_req_arbiter.sv
// Round-robin arbiter and sequencer that shares one dual-port RAM between NUM_REQ
// requesters. Each requester issues a paired command that writes both RAM ports or
// reads both RAM ports. The arbiter is the only master of the RAM command inputs. It
// follows the RAM ready handshake and returns write acks and read data tagged with
// the requester index.
//
// Ports:
//   clk, rstn              clock (rising edge) and asynchronous active-low reset
//   req/req_wr             per-requester request and type (1 = write, 0 = read)
//   req_addr_*/req_wdata_* flat payload buses; requester i occupies slice i
//   gnt                    one-hot, one-cycle grant pulse; the payload is latched
//   rsp_*                  completion pulse with id, type and read data
//   err_timeout/err_clr    sticky RAM-ready timeout flag and its clear input
//   ram_*                  RAM command, data and ready interface
module dpram_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned IDW        = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_a,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_b,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             rsp_valid,
  output logic [IDW-1:0]                   rsp_id,
  output logic                             rsp_wr,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_a,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_b,
  output logic                             err_timeout,
  input  logic                             err_clr,
  output logic                             ram_sel,
  output logic                             ram_wr,
  output logic [ADDR_WIDTH-1:0]            ram_addr_a,
  output logic [ADDR_WIDTH-1:0]            ram_addr_b,
  output logic [DATA_WIDTH-1:0]            ram_wdata_a,
  output logic [DATA_WIDTH-1:0]            ram_wdata_b,
  input  logic [DATA_WIDTH-1:0]            ram_rdata_a,
  input  logic [DATA_WIDTH-1:0]            ram_rdata_b,
  input  logic                             ram_ready
);

  localparam int unsigned CNTW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNTW-1:0] CntLast = CNTW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRdData, StRecover} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [IDW-1:0]         cmd_id_q, cmd_id_d;
  logic                   cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr_a_q, cmd_addr_a_d, cmd_addr_b_q, cmd_addr_b_d;
  logic [DATA_WIDTH-1:0]  cmd_wdata_a_q, cmd_wdata_a_d, cmd_wdata_b_q, cmd_wdata_b_d;
  logic [DATA_WIDTH-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]         rsp_id_q, rsp_id_d;
  logic                   rsp_wr_q, rsp_wr_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_a_q, rsp_rdata_a_d, rsp_rdata_b_q, rsp_rdata_b_d;
  logic                   err_q, err_d;

  logic                   win_found;
  logic [IDW-1:0]         win_id;
  logic [IDW:0]           rr_cand;
  logic                   done, abort;

  // Round-robin pick: first set request starting one past the last winner.
  // One extra bit holds ptr + offset before the wrap-around subtraction.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_cand = {1'b0, ptr_q} + (IDW+1)'(i + 1);
      if (rr_cand >= (IDW+1)'(NUM_REQ)) begin
        rr_cand = rr_cand - (IDW+1)'(NUM_REQ);
      end
      if (!win_found && req[rr_cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = rr_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    cmd_id_d      = cmd_id_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_addr_a_d  = cmd_addr_a_q;
    cmd_addr_b_d  = cmd_addr_b_q;
    cmd_wdata_a_d = cmd_wdata_a_q;
    cmd_wdata_b_d = cmd_wdata_b_q;
    rd_a_d        = rd_a_q;
    rd_b_d        = rd_b_q;
    gnt_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = '0;
    rsp_wr_d      = 1'b0;
    rsp_rdata_a_d = '0;
    rsp_rdata_b_d = '0;
    done          = 1'b0;
    abort         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          cmd_id_d      = win_id;
          cmd_wr_d      = req_wr[win_id];
          cmd_addr_a_d  = req_addr_a[win_id*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_addr_b_d  = req_addr_b[win_id*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_wdata_a_d = req_wdata_a[win_id*DATA_WIDTH +: DATA_WIDTH];
          cmd_wdata_b_d = req_wdata_b[win_id*DATA_WIDTH +: DATA_WIDTH];
          ptr_d         = win_id;
          gnt_d[win_id] = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (ram_ready) begin
          // The RAM acts on the command at this edge.
          if (cmd_wr_q) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRdData;
          end
        end else if (cnt_q == CntLast) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdData: begin
        // Read data is valid for this single cycle; sel stays high to re-arm the RAM.
        rd_a_d  = ram_rdata_a;
        rd_b_d  = ram_rdata_b;
        state_d = StRecover;
      end
      StRecover: begin
        if (ram_ready) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // An aborted transaction still completes so the requester is never orphaned.
    if (done || abort) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = cmd_id_q;
      rsp_wr_d    = cmd_wr_q;
      if (done && !cmd_wr_q) begin
        rsp_rdata_a_d = rd_a_q;
        rsp_rdata_b_d = rd_b_q;
      end
    end

    // Setting on abort takes priority over a same-cycle clear.
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      ptr_q         <= IDW'(NUM_REQ - 1);
      cnt_q         <= '0;
      cmd_id_q      <= '0;
      cmd_wr_q      <= 1'b0;
      cmd_addr_a_q  <= '0;
      cmd_addr_b_q  <= '0;
      cmd_wdata_a_q <= '0;
      cmd_wdata_b_q <= '0;
      rd_a_q        <= '0;
      rd_b_q        <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_wr_q      <= 1'b0;
      rsp_rdata_a_q <= '0;
      rsp_rdata_b_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      cmd_id_q      <= cmd_id_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_addr_a_q  <= cmd_addr_a_d;
      cmd_addr_b_q  <= cmd_addr_b_d;
      cmd_wdata_a_q <= cmd_wdata_a_d;
      cmd_wdata_b_q <= cmd_wdata_b_d;
      rd_a_q        <= rd_a_d;
      rd_b_q        <= rd_b_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rdata_a_q <= rsp_rdata_a_d;
      rsp_rdata_b_q <= rsp_rdata_b_d;
      err_q         <= err_d;
    end
  end

  // In RECOVER, sel is held only until the RAM reports ready again.
  always_comb begin
    ram_sel = 1'b0;
    unique case (state_q)
      StIssue:   ram_sel = 1'b1;
      StRdData:  ram_sel = 1'b1;
      StRecover: ram_sel = ~ram_ready;
      default:   ram_sel = 1'b0;
    endcase
  end

  assign ram_wr      = (state_q == StIssue) && cmd_wr_q;
  assign ram_addr_a  = cmd_addr_a_q;
  assign ram_addr_b  = cmd_addr_b_q;
  assign ram_wdata_a = cmd_wdata_a_q;
  assign ram_wdata_b = cmd_wdata_b_q;

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_wr      = rsp_wr_q;
  assign rsp_rdata_a = rsp_rdata_a_q;
  assign rsp_rdata_b = rsp_rdata_b_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_dpram_req_arbiter.sv
// Self-checking bench for dpram_req_arbiter. It contains a behavioural dual-port RAM
// (256x16, reset contents 0x2567, ready drops for one cycle after a read and re-arms
// while sel is high). It runs directed scenarios followed by randomized transactions.
// The randomized transactions are checked against a reference memory array and a
// round-robin grant rule.
module tb_dpram_req_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr_a = '0;
  logic [N*AW-1:0] req_addr_b = '0;
  logic [N*DW-1:0] req_wdata_a = '0;
  logic [N*DW-1:0] req_wdata_b = '0;
  logic [N-1:0]    gnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            rsp_wr;
  logic [DW-1:0]   rsp_rdata_a, rsp_rdata_b;
  logic            err_timeout;
  logic            err_clr = 1'b0;
  logic            ram_sel, ram_wr;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic            ram_ready;

  always #5 clk = ~clk;

  dpram_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_wr(req_wr),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .req_wdata_a(req_wdata_a), .req_wdata_b(req_wdata_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_wr(rsp_wr),
    .rsp_rdata_a(rsp_rdata_a), .rsp_rdata_b(rsp_rdata_b),
    .err_timeout(err_timeout), .err_clr(err_clr),
    .ram_sel(ram_sel), .ram_wr(ram_wr), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b), .ram_ready(ram_ready)
  );

  // RAM model; stall forces ready low to emulate a stuck RAM.
  logic          ram_rst = 1'b1;
  logic          stall = 1'b0;
  logic          rdy_q;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_a_q, rd_b_q;

  assign ram_ready   = rdy_q & ~stall;
  assign ram_rdata_a = rd_a_q;
  assign ram_rdata_b = rd_b_q;

  always @(posedge clk) begin
    if (ram_rst) begin
      rdy_q  <= 1'b1;
      rd_a_q <= '0;
      rd_b_q <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h2567;
    end else if (ram_sel && ram_ready) begin
      if (ram_wr) begin
        mem[ram_addr_a] <= ram_wdata_a;
        mem[ram_addr_b] <= ram_wdata_b;
      end else begin
        rd_a_q <= mem[ram_addr_a];
        rd_b_q <= mem[ram_addr_b];
        rdy_q  <= 1'b0;
      end
    end else if (ram_sel && !rdy_q) begin
      rdy_q <= 1'b1;
    end
  end

  // Reference state and requester payloads.
  int            n_assert = 0;
  int            n_fail = 0;
  logic [DW-1:0] ref_mem [256];
  int            ptr_ref;
  logic          p_wr [N];
  logic [AW-1:0] p_a [N];
  logic [AW-1:0] p_b [N];
  logic [DW-1:0] p_da [N];
  logic [DW-1:0] p_db [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pl(input int id, input logic wr, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [DW-1:0] da,
                        input logic [DW-1:0] db);
    p_wr[id] = wr; p_a[id] = a; p_b[id] = b; p_da[id] = da; p_db[id] = db;
  endtask

  task automatic drive(input logic [N-1:0] mask);
    req = mask;
    for (int i = 0; i < N; i++) begin
      req_wr[i]                 = p_wr[i];
      req_addr_a[i*AW +: AW]    = p_a[i];
      req_addr_b[i*AW +: AW]    = p_b[i];
      req_wdata_a[i*DW +: DW]   = p_da[i];
      req_wdata_b[i*DW +: DW]   = p_db[i];
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h2567;
  endtask

  task automatic ref_write(input int id);
    ref_mem[p_a[id]] = p_da[id];
    ref_mem[p_b[id]] = p_db[id];
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Reset both arbiter and RAM; release mid-cycle, away from the clock edge.
  task automatic full_reset();
    rstn = 1'b0; ram_rst = 1'b1;
    tick(); tick();
    #3;
    rstn = 1'b1; ram_rst = 1'b0;
    ref_reset();
    ptr_ref = N - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            w, sl, cyc, exp_lat;
    logic          got, seen;
    logic [N-1:0]  mask;
    logic [DW-1:0] ea, eb;

    // Reset state
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_sel", ram_sel, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_err", err_timeout, 0);
    #3; rstn = 1'b1; ram_rst = 1'b0;
    ref_reset(); ptr_ref = N - 1;
    tick();

    // Write then read back through requester 0
    set_pl(0, 1'b1, 8'h10, 8'h20, 16'hAAAA, 16'h5555);
    drive(4'b0001);
    tick();
    chk("t1_wr_gnt", gnt, 4'b0001);
    chk("t1_wr_ram_sel", ram_sel, 1);
    chk("t1_wr_ram_wr", ram_wr, 1);
    chk("t1_wr_ram_addr_a", ram_addr_a, 8'h10);
    req = '0;
    tick();
    chk("t1_wr_rsp", {rsp_valid, rsp_wr, rsp_id}, {1'b1, 1'b1, 2'd0});
    chk("t1_wr_rdata", {rsp_rdata_a, rsp_rdata_b}, 0);
    ref_write(0); ptr_ref = 0;
    set_pl(0, 1'b0, 8'h10, 8'h20, 16'h0, 16'h0);
    drive(4'b0001);
    tick();
    chk("t1_rd_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    chk("t1_rd_data_sel", {ram_sel, ram_wr}, 2'b10);
    tick();
    chk("t1_rd_early_rsp", rsp_valid, 0);
    tick();
    chk("t1_rd_rsp", {rsp_valid, rsp_wr, rsp_id}, {1'b1, 1'b0, 2'd0});
    chk("t1_rd_rdata", {rsp_rdata_a, rsp_rdata_b}, {16'hAAAA, 16'h5555});

    // Read of unwritten locations after a RAM reset
    ram_rst = 1'b1; tick(); ram_rst = 1'b0; ref_reset();
    set_pl(0, 1'b0, 8'h33, 8'h44, 16'h0, 16'h0);
    drive(4'b0001);
    tick(); req = '0;
    tick(); tick(); tick();
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rdata", {rsp_rdata_a, rsp_rdata_b}, {16'h2567, 16'h2567});

    // All four requesters writing continuously
    full_reset();
    tick();
    for (int i = 0; i < N; i++) set_pl(i, 1'b1, AW'(8'h40 + i), AW'(8'h50 + i),
                                       DW'(16'h1000 + i), DW'(16'h2000 + i));
    drive(4'b1111);
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("t3_gnt", gnt, 64'(1 << (g % N)));
      tick();
      chk("t3_rsp", {rsp_valid, rsp_wr, rsp_id}, {1'b1, 1'b1, 2'(g % N)});
      ref_write(g % N);
    end
    req = '0;
    ptr_ref = 1;
    tick();

    // Timeout while stuck in ISSUE
    set_pl(2, 1'b1, 8'h60, 8'h61, 16'hDEAD, 16'hBEEF);
    drive(4'b0100);
    stall = 1'b1;
    tick();
    chk("t4_gnt", gnt, 4'b0100);
    req = '0; ptr_ref = 2;
    repeat (TO - 1) tick();
    chk("t4_no_early_abort", {err_timeout, rsp_valid, ram_sel}, 3'b001);
    tick();
    chk("t4_err_set", err_timeout, 1);
    chk("t4_rsp", {rsp_valid, rsp_wr, rsp_id}, {1'b1, 1'b1, 2'd2});
    chk("t4_rdata", {rsp_rdata_a, rsp_rdata_b}, 0);
    chk("t4_idle_sel", ram_sel, 0);
    stall = 1'b0;
    tick();
    chk("t4_err_sticky", {err_timeout, rsp_valid}, 2'b10);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_err_clr", err_timeout, 0);
    // A clear in the same cycle as an abort loses to the set
    set_pl(3, 1'b1, 8'h62, 8'h63, 16'h1234, 16'h5678);
    drive(4'b1000);
    stall = 1'b1; err_clr = 1'b1;
    tick();
    chk("t4b_gnt", gnt, 4'b1000);
    req = '0; ptr_ref = 3;
    repeat (TO) tick();
    chk("t4b_set_wins", {err_timeout, rsp_valid}, 2'b11);
    stall = 1'b0; err_clr = 1'b0;
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4b_err_clr", err_timeout, 0);

    // Asynchronous reset while in RD_DATA
    set_pl(1, 1'b0, 8'h10, 8'h20, 16'h0, 16'h0);
    drive(4'b0010);
    tick();
    chk("t5_gnt", gnt, 4'b0010);
    req = '0;
    tick();
    chk("t5_rd_data_sel", ram_sel, 1);
    #3;
    rstn = 1'b0; ram_rst = 1'b1;
    #1;
    chk("t5_async_ctl", {gnt, rsp_valid, rsp_wr, rsp_id, err_timeout, ram_sel, ram_wr}, 0);
    chk("t5_async_addr", {ram_addr_a, ram_addr_b}, 0);
    chk("t5_async_rdata", {rsp_rdata_a, rsp_rdata_b}, 0);
    tick(); tick();
    #3; rstn = 1'b1; ram_rst = 1'b0;
    ref_reset(); ptr_ref = N - 1;
    seen = 1'b0;
    repeat (4) begin tick(); seen = seen | rsp_valid; end
    chk("t5_no_orphan_rsp", seen, 0);
    for (int i = 0; i < N; i++) set_pl(i, 1'b1, AW'(8'h70 + i), AW'(8'h78 + i),
                                       DW'(16'h3000 + i), DW'(16'h4000 + i));
    drive(4'b1111);
    tick();
    chk("t5_first_gnt", gnt, 4'b0001);
    req = '0; ptr_ref = 0;
    tick();
    ref_write(0);

    // Requester 1 re-requests right after its grant
    set_pl(1, 1'b1, 8'h80, 8'h81, 16'h0101, 16'h1010);
    set_pl(3, 1'b1, 8'h82, 8'h83, 16'h0303, 16'h3030);
    drive(4'b1010);
    tick();
    chk("t6_gnt0", gnt, 4'b0010);
    req = 4'b1000;
    tick();
    chk("t6_rsp0", {rsp_valid, rsp_id}, {1'b1, 2'd1});
    req = 4'b1010;
    tick();
    chk("t6_gnt1", gnt, 4'b1000);
    req = 4'b0010;
    tick();
    chk("t6_rsp1", {rsp_valid, rsp_id}, {1'b1, 2'd3});
    tick();
    chk("t6_gnt2", gnt, 4'b0010);
    req = '0;
    tick();
    chk("t6_rsp2", {rsp_valid, rsp_id}, {1'b1, 2'd1});
    ref_write(1); ref_write(3);
    ptr_ref = 1;

    // Randomized transactions against the reference memory and round-robin rule
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        p_wr[i] = 1'($urandom_range(0, 1));
        p_a[i]  = AW'($urandom_range(0, 31));
        p_b[i]  = AW'((p_a[i] + 1 + $urandom_range(0, 30)) % 32);
        p_da[i] = DW'($urandom);
        p_db[i] = DW'($urandom);
      end
      sl = $urandom_range(0, 3);
      w  = rr_pick(mask, ptr_ref);
      drive(mask);
      stall = (sl != 0);
      tick(); cyc = 1;
      chk("rnd_gnt", gnt, 64'(1 << w));
      ptr_ref = w;
      req = '0;
      got = 1'b0;
      while (!got && cyc < 12) begin
        tick(); cyc++;
        if (cyc == sl + 1) stall = 1'b0;
        got = rsp_valid;
      end
      stall = 1'b0;
      chk("rnd_rsp_seen", got, 1);
      exp_lat = p_wr[w] ? sl + 2 : sl + 4;
      chk("rnd_latency", cyc, exp_lat);
      chk("rnd_rsp_id_wr", {rsp_id, rsp_wr}, {2'(w), p_wr[w]});
      ea = p_wr[w] ? '0 : ref_mem[p_a[w]];
      eb = p_wr[w] ? '0 : ref_mem[p_b[w]];
      chk("rnd_rdata", {rsp_rdata_a, rsp_rdata_b}, {ea, eb});
      if (p_wr[w]) ref_write(w);
    end
    chk("rnd_err_clear", err_timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_req_arbiter.md
Name: dpram_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one dual-port RAM (dual_port, 256x16) between NUM_REQ requesters.
Each requester issues a paired command: either one write of both ports or one read of both ports.
The arbiter is the sole master of the RAM sel/wr/addr/wdata inputs. It follows the RAM's ready protocol: a read drops ready for one cycle and needs sel held high to re-arm it.
It returns read data and write acks with the requester ID.

Parameters:
NUM_REQ, 4, number of requesters (2..8); IDW = $clog2(NUM_REQ) is derived locally.
ADDR_WIDTH, 8, RAM address width.
DATA_WIDTH, 16, RAM data width.
TIMEOUT_CYC, 16, maximum cycles spent waiting on ram_ready before an abort.

Ports:
clk  in  1  clock; everything is rising-edge.
rstn  in  1  asynchronous active-low reset.
req  in  NUM_REQ  per-requester request; hold high with a stable payload until granted.
req_wr  in  NUM_REQ  1 = write, 0 = read.
req_addr_a  in  NUM_REQ*ADDR_WIDTH  flat port-A address; requester i occupies slice i.
req_addr_b  in  NUM_REQ*ADDR_WIDTH  flat port-B address.
req_wdata_a  in  NUM_REQ*DATA_WIDTH  flat port-A write data.
req_wdata_b  in  NUM_REQ*DATA_WIDTH  flat port-B write data.
gnt  out  NUM_REQ  one-hot, one-cycle pulse; the payload has been latched.
rsp_valid  out  1  one-cycle pulse; the transaction is complete.
rsp_id  out  IDW  requester index of the completed transaction.
rsp_wr  out  1  type of the completed transaction.
rsp_rdata_a  out  DATA_WIDTH  port-A read data (0 for writes).
rsp_rdata_b  out  DATA_WIDTH  port-B read data (0 for writes).
err_timeout  out  1  sticky; set by a timeout abort, cleared by err_clr or reset.
err_clr  in  1  clears err_timeout.
ram_sel  out  1  to RAM sel.
ram_wr  out  1  to RAM wr.
ram_addr_a  out  ADDR_WIDTH  to RAM addrA.
ram_addr_b  out  ADDR_WIDTH  to RAM addrB.
ram_wdata_a  out  DATA_WIDTH  to RAM wdataA.
ram_wdata_b  out  DATA_WIDTH  to RAM wdataB.
ram_rdata_a  in  DATA_WIDTH  from RAM rdataA.
ram_rdata_b  in  DATA_WIDTH  from RAM rdataB.
ram_ready  in  1  from RAM ready.

Behaviour:
- Reset (async): state=IDLE, RR pointer=NUM_REQ-1 (so req[0] wins first), timeout counter=0. All outputs 0. Any in-flight transaction is dropped with no rsp_valid after release.
- Command registers (id, wr, addrs, wdata) are latched at the IDLE exit edge. ram_addr_*, ram_wdata_* and ram_wr are driven from these registers.
- ram_sel is decoded combinationally from state and ram_ready:
  - ISSUE: 1.
  - RD_DATA: 1.
  - RECOVER: ~ram_ready.
  - IDLE: 0.
- ram_wr = 0 in RD_DATA and RECOVER.
- IDLE:
  - If any req bit is set, pick the first set bit searching from pointer+1 with wrap-around.
  - Latch that requester's payload, set pointer=winner, pulse gnt[winner] in the next cycle, go ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - ram_ready=1 and wr=1: the RAM writes at this edge. Go IDLE; next cycle rsp_valid=1, rsp_wr=1, rdata=0.
  - ram_ready=1 and wr=0: the RAM samples the read at this edge. Go RD_DATA.
  - ram_ready=0: stay in ISSUE and count.
- RD_DATA (exactly one cycle): ram_rdata_* are valid and ram_ready=0.
  - Capture ram_rdata_a/b into rsp_rdata_a/b.
  - sel=1 with ram_ready=0 re-arms the RAM without starting a new read.
  - Go RECOVER.
- RECOVER: when ram_ready=1, go IDLE and pulse rsp_valid in the next cycle. Otherwise stay and count.
- Nominal timing, grant-decision cycle = C0:
  - Write: gnt in C1, RAM write at the end of C1, rsp_valid in C2, new arbitration in C2.
  - Read: gnt in C1, rsp_valid in C4, new arbitration in C4.
- Timeout:
  - The counter clears on every state change.
  - If TIMEOUT_CYC consecutive cycles pass in ISSUE or RECOVER with ram_ready=0, set err_timeout and go IDLE.
  - Then pulse rsp_valid with rdata=0 so the requester is never orphaned.
- err_clr and a same-cycle abort together: set wins.
- A req that drops before grant is legal; it is simply not served. A req still high after its gnt is treated as a new request.
- A requester can win at most once per NUM_REQ grants while others are waiting.
- The RAM's own synchronous reset is driven externally. The arbiter must be in IDLE (ram_sel=0) while the RAM is held in reset.

Test Plan:
1. Req0 writes A=0x10 ← 0xAAAA, B=0x20 ← 0x5555, then reads 0x10/0x20 → write rsp_valid 2 cycles after the decision, with rsp_wr=1. The read returns rsp_rdata_a=0xAAAA, rsp_rdata_b=0x5555, rsp_id=0, with rsp_valid 4 cycles after the decision.
2. Read of A=0x33/B=0x44 after RAM reset with no prior write → both rdata = 0x2567.
3. All 4 requesters hold write requests continuously → gnt order 0,1,2,3,0,1, one grant every 2 cycles, rsp_id matching each grant.
4. RAM model forces ram_ready=0 during ISSUE → after 16 cycles err_timeout=1, then rsp_valid with rdata=0 and state IDLE. err_clr → err_timeout=0.
5. rstn asserted mid-cycle while in RD_DATA → all outputs are 0 asynchronously. After release there is no rsp_valid, and the first grant goes to req[0].
6. Req1 and req3 request, then req1 re-requests immediately after its gnt → order is 1,3,1.
